// File: rtl/synth_pkg.sv
// synth_pkg: types and constants shared along the synth sample path.
//   SLOTS_PER_FRAME : I2S slots per frame (two 16-bit channels)
//   LOAD_SLOT       : slot whose starting BCLK falling edge loads a new frame
//   i2s_state_t     : serializer control states
//   sample_t        : two's-complement audio sample
//   slot_t          : slot counter type
//   next_slot()     : slot counter increment with wrap at end of frame
package synth_pkg;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int LOAD_SLOT       = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  typedef logic signed [15:0] sample_t;
  typedef logic [4:0]         slot_t;

  function automatic slot_t next_slot(input slot_t s);
    return (s == 5'(SLOTS_PER_FRAME - 1)) ? 5'd0 : s + 5'd1;
  endfunction

endpackage

// File: rtl/bclk_divider.sv
// bclk_divider: derives the I2S bit clock from the system clock.
//   clk   in  : system clock
//   reset in  : asynchronous, active-low reset
//   run   in  : count while high; counter and bclk held at 0 while low
//   clear in  : restart the BCLK period from div_cnt = 0
//   bclk  out : registered bit clock, low for the first half of each period
//   fall  out : one-clk strobe in the last cycle of a period; the register
//               update on that cycle's clock edge is the BCLK falling edge
module bclk_divider #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic bclk,
  output logic fall
);

  localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BCLK_DIV / 2);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
  end

  assign fall = run && (div_cnt == LAST);

  // bclk is registered from the next count so it lines up with div_cnt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (clear || !run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= cnt_next;
      bclk    <= (cnt_next >= HALF);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono sample to I2S serializer driving the external DAC.
//   clk          in  : system clock
//   reset        in  : asynchronous, active-low reset
//   enable       in  : run request; drop stops at the next frame boundary
//   sample       in  : two's-complement sample from the oscillator
//   sample_valid in  : sample is valid this cycle
//   sample_ready out : holding register empty (transfer on valid && ready)
//   bclk         out : I2S bit clock
//   lrclk        out : word select, 0 = left, 1 = right
//   sdata        out : serial data, MSB first, one-slot I2S delay
//   underrun     out : one-clk pulse when a frame loads with nothing buffered
//   busy         out : high while running
module i2s_tx
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun,
  output logic                busy
);

  localparam int FRAME_W = 2 * SAMPLE_W;

  i2s_state_t          state_q;
  i2s_state_t          state_d;
  logic [SAMPLE_W-1:0] hold;
  logic                hold_full;
  logic [FRAME_W-1:0]  shift_reg;
  slot_t               slot;
  slot_t               slot_nxt;
  logic                stop_pending;
  logic                run;
  logic                start;
  logic                fall;
  logic                xfer;
  logic                load_edge;
  logic                drain;
  logic                stop_exit;
  logic                lrclk_q;
  logic                sdata_q;
  logic                underrun_q;
  logic                busy_q;

  assign sample_ready = !hold_full;
  assign xfer         = sample_valid && !hold_full;
  assign run          = (state_q == RUN);
  assign start        = (state_q == IDLE) && (state_d == RUN);
  assign slot_nxt     = next_slot(slot);
  assign load_edge    = run && fall && (slot_nxt == 5'(LOAD_SLOT));
  assign drain        = load_edge && !stop_pending && hold_full;
  // A stopping frame plays out slot 0 and an empty slot 1, then leaves RUN
  assign stop_exit    = run && fall && stop_pending && (slot == 5'(LOAD_SLOT));

  bclk_divider #(
    .BCLK_DIV(BCLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .clear(start),
    .bclk (bclk),
    .fall (fall)
  );

  // A sample arriving in the same cycle counts as buffered, so RUN begins
  // one cycle after the transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && (hold_full || xfer)) state_d = RUN;
      RUN:     if (stop_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
    end
  end

  // Transfers and drains never coincide: a transfer needs the hold empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
    end else if (xfer) begin
      hold_full <= 1'b1;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) hold <= sample;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot         <= '0;
      shift_reg    <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      stop_pending <= 1'b0;
    end else if (start) begin
      slot         <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= shift_reg[FRAME_W-1];
      underrun_q   <= 1'b0;
      stop_pending <= 1'b0;
    end else if (!run) begin
      slot         <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (fall) begin
        if (stop_exit) begin
          slot      <= '0;
          lrclk_q   <= 1'b0;
          sdata_q   <= 1'b0;
          shift_reg <= '0;
        end else begin
          slot    <= slot_nxt;
          lrclk_q <= (slot_nxt >= 5'(SAMPLE_W));
          if (slot_nxt == 5'd0) stop_pending <= !enable;
          if (load_edge) begin
            // The loaded MSB goes straight to sdata; the rest follows by shifting
            if (stop_pending) begin
              sdata_q   <= 1'b0;
              shift_reg <= '0;
            end else if (hold_full) begin
              sdata_q   <= hold[SAMPLE_W-1];
              shift_reg <= {hold[SAMPLE_W-2:0], hold, 1'b0};
            end else begin
              sdata_q    <= 1'b0;
              shift_reg  <= '0;
              underrun_q <= 1'b1;
            end
          end else begin
            sdata_q   <= shift_reg[FRAME_W-1];
            shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed self-checking bench for i2s_tx at BCLK_DIV = 4.
module tb_i2s_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
  logic        busy;

  int err_cnt;
  int chk_cnt;
  int und_cnt;

  i2s_tx #(
    .SAMPLE_W(16),
    .BCLK_DIV(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .underrun    (underrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (underrun === 1'b1) und_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    steps(2);
    reset = 1'b1;
    step();
  endtask

  logic [31:0] cap;
  logic [31:0] lcap;
  logic [30:0] cap2;
  int          bad;
  int          w;
  int          n;
  logic        sd[0:359];
  logic        rd[0:359];
  int          xt[0:3];
  int          nx;
  int          idx;
  logic        pending;
  logic [15:0] words[0:2];

  initial begin
    err_cnt      = 0;
    chk_cnt      = 0;
    und_cnt      = 0;
    reset        = 1'b0;
    enable       = 1'b0;
    sample       = 16'h5555;
    sample_valid = 1'b1;

    // Reset held with a sample pending
    steps(3);
    check_val("rst_bclk",  {31'd0, bclk},         32'd0);
    check_val("rst_lrclk", {31'd0, lrclk},        32'd0);
    check_val("rst_sdata", {31'd0, sdata},        32'd0);
    check_val("rst_und",   {31'd0, underrun},     32'd0);
    check_val("rst_busy",  {31'd0, busy},         32'd0);
    check_val("rst_ready", {31'd0, sample_ready}, 32'd1);

    // Release with enable low and send 0x1234: buffered, stays idle
    reset  = 1'b1;
    sample = 16'h1234;
    step();
    sample_valid = 1'b0;
    check_val("idle_ready", {31'd0, sample_ready}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bclk !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_val("idle_hold", bad, 0);
    reset_pulse();
    check_val("discard_ready", {31'd0, sample_ready}, 32'd1);

    // Single 0xA5F0 with enable high
    und_cnt      = 0;
    enable       = 1'b1;
    sample       = 16'hA5F0;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check_val("t1_busy",  {31'd0, busy},         32'd1);
    check_val("t1_bclk",  {31'd0, bclk},         32'd0);
    step();
    check_val("t2_bclk",  {31'd0, bclk},         32'd0);
    step();
    check_val("t3_bclk",  {31'd0, bclk},         32'd1);
    steps(2);
    check_val("t5_sdata", {31'd0, sdata},        32'd1);
    check_val("t5_ready", {31'd0, sample_ready}, 32'd1);
    check_val("t5_bclk",  {31'd0, bclk},         32'd0);
    steps(2);
    cap  = '0;
    lcap = '0;
    for (int k = 1; k <= 32; k++) begin
      cap  = {cap[30:0], sdata};
      lcap = {lcap[30:0], lrclk};
      steps(4);
    end
    check_val("a5f0_data",  cap,  32'hA5F0A5F0);
    check_val("a5f0_lrclk", lcap, 32'h0001FFFE);

    // Frame 2 starved, enable dropped mid-frame
    cap2 = '0;
    for (int k = 1; k <= 31; k++) begin
      cap2 = {cap2[29:0], sdata};
      if (k == 18) enable = 1'b0;
      if (k < 31) steps(4);
    end
    check_val("starve_data", {1'b0, cap2}, 32'd0);
    w = 0;
    while (lrclk !== 1'b0 && w < 8) begin
      step();
      w++;
    end
    check_val("wrap_seen", {31'd0, lrclk}, 32'd0);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check_val("stop_delay", n, 8);
    check_val("starve_und", und_cnt, 1);
    check_val("stop_bclk",  {31'd0, bclk},  32'd0);
    check_val("stop_sdata", {31'd0, sdata}, 32'd0);
    steps(10);
    check_val("stop_idle",  {31'd0, busy},  32'd0);

    // Back-to-back 0x8000, 0x7FFF with an always-valid source
    reset_pulse();
    und_cnt      = 0;
    enable       = 1'b1;
    words[0]     = 16'h8000;
    words[1]     = 16'h7FFF;
    words[2]     = 16'h0001;
    idx          = 0;
    nx           = 0;
    pending      = 1'b0;
    sample       = words[0];
    sample_valid = 1'b1;
    sd[0]        = sdata;
    rd[0]        = sample_ready;
    for (int j = 0; j < 359; j++) begin
      if (sample_ready && sample_valid) begin
        if (nx < 4) xt[nx] = j;
        nx++;
        pending = 1'b1;
      end
      step();
      if (pending) begin
        if (idx < 2) idx++;
        sample  = words[idx];
        pending = 1'b0;
      end
      sd[j+1] = sdata;
      rd[j+1] = sample_ready;
    end
    sample_valid = 1'b0;
    if (nx < 3) begin
      check_val("b2b_xfers", nx, 3);
    end else begin
      check_val("b2b_first_load", xt[1] - xt[0], 5);
      check_val("b2b_spacing",    xt[2] - xt[1], 128);
      bad = 0;
      for (int j = xt[1] + 1; j < xt[2]; j++) if (rd[j] !== 1'b0) bad++;
      check_val("b2b_ready_low", bad, 0);
      check_val("w0_slot1",  {31'd0, sd[xt[1]]},      32'd1);
      check_val("w0_slot2",  {31'd0, sd[xt[1] + 4]},  32'd0);
      check_val("w0_slot17", {31'd0, sd[xt[1] + 64]}, 32'd1);
      check_val("w1_slot1",  {31'd0, sd[xt[2]]},      32'd0);
      check_val("w1_slot2",  {31'd0, sd[xt[2] + 4]},  32'd1);
      check_val("w1_slot17", {31'd0, sd[xt[2] + 64]}, 32'd0);
    end
    check_val("b2b_und", und_cnt, 0);

    // Reset asserted at slot 10 with a second sample buffered
    reset_pulse();
    enable       = 1'b1;
    sample       = 16'hFFFF;
    sample_valid = 1'b1;
    step();
    sample = 16'h5555;
    steps(4);
    step();
    sample_valid = 1'b0;
    steps(37);
    check_val("s10_bclk",  {31'd0, bclk},         32'd1);
    check_val("s10_sdata", {31'd0, sdata},        32'd1);
    check_val("s10_ready", {31'd0, sample_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("arst_bclk",  {31'd0, bclk},         32'd0);
    check_val("arst_sdata", {31'd0, sdata},        32'd0);
    check_val("arst_busy",  {31'd0, busy},         32'd0);
    check_val("arst_lrclk", {31'd0, lrclk},        32'd0);
    check_val("arst_ready", {31'd0, sample_ready}, 32'd1);
    steps(2);
    reset = 1'b1;
    step();

    // Clean restart with 0xC000
    sample       = 16'hC000;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check_val("rs_busy",  {31'd0, busy},  32'd1);
    steps(4);
    check_val("rs_slot1", {31'd0, sdata}, 32'd1);
    steps(4);
    check_val("rs_slot2", {31'd0, sdata}, 32'd1);
    steps(4);
    check_val("rs_slot3", {31'd0, sdata}, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
